// File: rtl/go_initiator_pkg.sv
// go_initiator_pkg: shared FSM state encoding, status counter width and
// the saturating-increment helper used by the go/kill/done initiator.
package go_initiator_pkg;

    localparam int unsigned FAIL_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_KILL    = 3'd3,
        ST_RECOVER = 3'd4
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
        return (v == '1) ? v : v + FAIL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/go_timer.sv
// go_timer: clearable, loadable up/down counter. The initiator time-shares
// one instance between the WAIT-state cycle count and the kill-hold count.
// Priority: clear > load > increment > decrement.
module go_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Select the next count from the prioritised controls.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/go_initiator.sv
// go_initiator: launches a job on a worker with a one-cycle go pulse, waits
// for done, kills a stalled worker with a KILL_CYCLES-long kill burst, retries
// up to MAX_RETRY times and reports a one-cycle pass or fail.
// Optional build macro GO_INITIATOR_LATENCY_CAPTURE_EN adds the last_latency
// port, which records the wait count at each accepted done.
module go_initiator
    import go_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 200,
    parameter int unsigned TMO_W       = 8,
    parameter int unsigned KILL_CYCLES = 2,
    parameter int unsigned MAX_RETRY   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  done,
    output logic                  go,
    output logic                  kill,
    output logic                  busy,
    output logic                  pass,
    output logic                  fail,
    output logic [FAIL_CNT_W-1:0] fail_cnt
`ifdef GO_INITIATOR_LATENCY_CAPTURE_EN
    ,
    output logic [TMO_W-1:0]      last_latency
`endif
);

    localparam int unsigned       RTRY_W       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TMO_W-1:0]  TIMEOUT_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  KILL_LAST    = TMO_W'(KILL_CYCLES - 1);
    localparam logic [RTRY_W-1:0] RETRY_LAST   = RTRY_W'(MAX_RETRY);

    state_e                  state_q, state_d;
    logic [RTRY_W-1:0]       retry_q, retry_d;
    logic                    force_q, force_d;

    logic                    go_q, go_d;
    logic                    kill_q, kill_d;
    logic                    busy_q, busy_d;
    logic                    pass_q, pass_d;
    logic                    fail_q, fail_d;
    logic [FAIL_CNT_W-1:0]   fail_cnt_q, fail_cnt_d;

    logic                    tmr_clr, tmr_load, tmr_inc, tmr_dec;
    logic                    tmr_zero;
    logic [TMO_W-1:0]        wait_cnt;
    logic                    timeout_hit;
    logic                    rec_fail;

    // The timer holds wait_cnt while in WAIT and the remaining kill-hold
    // cycles while in KILL; it is reloaded on every entry into KILL.
    go_timer #(
        .W (TMO_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (KILL_LAST),
        .inc_i      (tmr_inc),
        .dec_i      (tmr_dec),
        .cnt_o      (wait_cnt),
        .zero_o     (tmr_zero)
    );

    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
    assign rec_fail    = force_q || abort || (retry_q == RETRY_LAST);

    // State, retry count and forced-fail flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            retry_q <= '0;
            force_q <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            force_q <= force_d;
        end
    end

    // Next state; done beats timeout, and timeout beats abort, in WAIT.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        force_d = force_q;
        case (state_q)
            ST_IDLE: begin
                force_d = 1'b0;
                if (start) begin
                    state_d = ST_LAUNCH;
                    retry_d = '0;
                end
            end
            ST_LAUNCH: begin
                if (abort) begin
                    state_d = ST_KILL;
                    force_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    state_d = ST_KILL;
                end else if (abort) begin
                    state_d = ST_KILL;
                    force_d = 1'b1;
                end
            end
            ST_KILL: begin
                if (tmr_zero) begin
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (rec_fail) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LAUNCH;
                    retry_d = retry_q + RTRY_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered-output next values and timer control.
    always_comb begin
        go_d       = (state_d == ST_LAUNCH);
        kill_d     = (state_d == ST_KILL);
        busy_d     = (state_d != ST_IDLE);
        pass_d     = (state_q == ST_WAIT) && done;
        fail_d     = (state_q == ST_RECOVER) && rec_fail;
        fail_cnt_d = fail_d ? sat_inc(fail_cnt_q) : fail_cnt_q;

        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_inc  = 1'b0;
        tmr_dec  = 1'b0;
        if (kill_d && (state_q != ST_KILL)) begin
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                ST_WAIT: tmr_inc = 1'b1;
                ST_KILL: tmr_dec = !tmr_zero;
                default: tmr_clr = 1'b1;
            endcase
        end
    end

    // Output and status registers; reset drops go/kill immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            go_q       <= 1'b0;
            kill_q     <= 1'b0;
            busy_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            fail_cnt_q <= '0;
        end else begin
            go_q       <= go_d;
            kill_q     <= kill_d;
            busy_q     <= busy_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign go       = go_q;
    assign kill     = kill_q;
    assign busy     = busy_q;
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign fail_cnt = fail_cnt_q;

`ifdef GO_INITIATOR_LATENCY_CAPTURE_EN
    logic [TMO_W-1:0] last_latency_q;

    // Capture wait_cnt on each done accepted in WAIT, hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_latency_q <= '0;
        end else if (pass_d) begin
            last_latency_q <= wait_cnt;
        end
    end

    assign last_latency = last_latency_q;
`endif

endmodule
